// File: rtl/io_bus_bridge.sv
// Byte-bus bridge between the CPU, the 128 KB synchronous RAM and the memory-mapped I/O window.
// Owns the UART TX/RX FIFOs, the cycle counter with tear-free snapshot, and the program-stop flag.
module io_bus_bridge #(
    parameter int TX_DEPTH_LOG = 4,
    parameter int RX_DEPTH_LOG = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_din,
    output logic        io_buffer_full,
    output logic [16:0] ram_a,
    output logic        ram_we,
    output logic [7:0]  ram_din,
    input  logic [7:0]  ram_dout,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        program_done,
    output logic        tx_overflow
);

    localparam int TX_DEPTH = 1 << TX_DEPTH_LOG;
    localparam int RX_DEPTH = 1 << RX_DEPTH_LOG;
    localparam logic [TX_DEPTH_LOG:0] TX_ALMOST_FULL = (TX_DEPTH_LOG + 1)'(TX_DEPTH - 1);
    localparam logic [TX_DEPTH_LOG:0] TX_PTR_ONE = (TX_DEPTH_LOG + 1)'(1);
    localparam logic [RX_DEPTH_LOG:0] RX_PTR_ONE = (RX_DEPTH_LOG + 1)'(1);

    logic                  ioSel_q, ioSel_d;
    logic [7:0]            ioData_q, ioData_d;
    logic [31:0]           cycleCnt_q, cycleCnt_d;
    logic [31:0]           cntSnap_q, cntSnap_d;
    logic                  programDone_q, programDone_d;
    logic                  txOverflow_q, txOverflow_d;
    logic [TX_DEPTH_LOG:0] txWrPtr_q, txWrPtr_d, txRdPtr_q, txRdPtr_d, txCount;
    logic [RX_DEPTH_LOG:0] rxWrPtr_q, rxWrPtr_d, rxRdPtr_q, rxRdPtr_d;
    logic [7:0]            txMem_q [TX_DEPTH];
    logic [7:0]            rxMem_q [RX_DEPTH];

    logic       isIo, ioWr, ioRd;
    logic       txFull, txEmpty, txPop, txPushReq, txPush;
    logic [7:0] txPushData;
    logic       rxFull, rxEmpty, rxPop, rxPush;
    logic [7:0] rxHead;
    logic [13:0] unusedAddrBits;

    assign unusedAddrBits = cpu_a[31:18];

    assign isIo = cpu_a[17] & cpu_a[16];
    assign ioWr = isIo & cpu_wr & ~programDone_q;
    assign ioRd = isIo & ~cpu_wr;

    assign ram_a   = cpu_a[16:0];
    assign ram_din = cpu_dout;
    assign ram_we  = cpu_wr & ~cpu_a[17] & rst_in;

    // Full is detected by the extra pointer MSB: same slot, different lap.
    assign txCount = txWrPtr_q - txRdPtr_q;
    assign txEmpty = (txWrPtr_q == txRdPtr_q);
    assign txFull  = (txWrPtr_q[TX_DEPTH_LOG] != txRdPtr_q[TX_DEPTH_LOG]) &&
                     (txWrPtr_q[TX_DEPTH_LOG-1:0] == txRdPtr_q[TX_DEPTH_LOG-1:0]);
    assign txPop      = ~txEmpty & uart_tx_ready;
    assign txPushReq  = ioWr & (((cpu_a[2:0] == 3'd0) && (cpu_dout != 8'h00)) || (cpu_a[2:0] == 3'd4));
    assign txPushData = (cpu_a[2:0] == 3'd4) ? 8'h00 : cpu_dout;
    assign txPush     = txPushReq & (~txFull | txPop);

    assign rxEmpty = (rxWrPtr_q == rxRdPtr_q);
    assign rxFull  = (rxWrPtr_q[RX_DEPTH_LOG] != rxRdPtr_q[RX_DEPTH_LOG]) &&
                     (rxWrPtr_q[RX_DEPTH_LOG-1:0] == rxRdPtr_q[RX_DEPTH_LOG-1:0]);
    assign rxHead  = rxMem_q[rxRdPtr_q[RX_DEPTH_LOG-1:0]];
    assign rxPop   = ioRd & (cpu_a[2:0] == 3'd0) & ~rxEmpty;
    assign rxPush  = uart_rx_valid & (~rxFull | rxPop);

    assign uart_tx_data   = txMem_q[txRdPtr_q[TX_DEPTH_LOG-1:0]];
    assign uart_tx_valid  = ~txEmpty;
    assign io_buffer_full = (txCount >= TX_ALMOST_FULL);
    assign program_done   = programDone_q;
    assign tx_overflow    = txOverflow_q;
    assign cpu_din        = ioSel_q ? ioData_q : ram_dout;

    always_comb begin
        ioSel_d       = cpu_a[17];
        ioData_d      = 8'h00;
        cycleCnt_d    = cycleCnt_q + 32'd1;
        cntSnap_d     = cntSnap_q;
        programDone_d = programDone_q;
        txOverflow_d  = txOverflow_q;
        txWrPtr_d     = txPush ? txWrPtr_q + TX_PTR_ONE : txWrPtr_q;
        txRdPtr_d     = txPop  ? txRdPtr_q + TX_PTR_ONE : txRdPtr_q;
        rxWrPtr_d     = rxPush ? rxWrPtr_q + RX_PTR_ONE : rxWrPtr_q;
        rxRdPtr_d     = rxPop  ? rxRdPtr_q + RX_PTR_ONE : rxRdPtr_q;

        if (txPushReq && !txPush) begin
            txOverflow_d = 1'b1;
        end
        if (ioWr && (cpu_a[2:0] == 3'd4)) begin
            programDone_d = 1'b1;
        end
        // Byte 0 is live and snapshots the whole counter so bytes 1-3 stay coherent with it.
        if (ioRd) begin
            case (cpu_a[2:0])
                3'd0: ioData_d = rxEmpty ? 8'h00 : rxHead;
                3'd4: begin
                    ioData_d  = cycleCnt_q[7:0];
                    cntSnap_d = cycleCnt_q;
                end
                3'd5:    ioData_d = cntSnap_q[15:8];
                3'd6:    ioData_d = cntSnap_q[23:16];
                3'd7:    ioData_d = cntSnap_q[31:24];
                default: ioData_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            ioSel_q       <= 1'b1;
            ioData_q      <= 8'h00;
            cycleCnt_q    <= 32'd0;
            cntSnap_q     <= 32'd0;
            programDone_q <= 1'b0;
            txOverflow_q  <= 1'b0;
            txWrPtr_q     <= '0;
            txRdPtr_q     <= '0;
            rxWrPtr_q     <= '0;
            rxRdPtr_q     <= '0;
        end else begin
            ioSel_q       <= ioSel_d;
            ioData_q      <= ioData_d;
            cycleCnt_q    <= cycleCnt_d;
            cntSnap_q     <= cntSnap_d;
            programDone_q <= programDone_d;
            txOverflow_q  <= txOverflow_d;
            txWrPtr_q     <= txWrPtr_d;
            txRdPtr_q     <= txRdPtr_d;
            rxWrPtr_q     <= rxWrPtr_d;
            rxRdPtr_q     <= rxRdPtr_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in && txPush) begin
            txMem_q[txWrPtr_q[TX_DEPTH_LOG-1:0]] <= txPushData;
        end
        if (rst_in && rxPush) begin
            rxMem_q[rxWrPtr_q[RX_DEPTH_LOG-1:0]] <= uart_rx_data;
        end
    end

endmodule

// File: doc/io_bus_bridge.md
# io_bus_bridge

Memory-side bridge on the CPU's byte bus (`mem_a`/`mem_dout`/`mem_wr` in, `mem_din`/`io_buffer_full` out). It splits CPU accesses between the 128 KB synchronous RAM and the memory-mapped I/O window. It owns the UART TX/RX FIFOs, the free-running cycle counter, and the program-stop flag. It returns read data with the one-cycle latency the CPU's memctrl expects.

## Interface
- `TX_DEPTH_LOG`, 4, log2 of TX FIFO depth (depth 16).
- `RX_DEPTH_LOG`, 4, log2 of RX FIFO depth.
- `clk_in`  in  1  system clock.
- `rst_in`  in  1  reset. One clock; reset is synchronous and active-low.
- `cpu_a`  in  32  CPU byte address; only [17:0] decoded.
- `cpu_dout`  in  8  CPU write data.
- `cpu_wr`  in  1  1 = write, 0 = read; sampled every cycle.
- `cpu_din`  out  8  read data, valid one cycle after the address.
- `io_buffer_full`  out  1  TX FIFO almost full; CPU must not issue UART writes.
- `ram_a`  out  17  RAM address.
- `ram_we`  out  1  RAM write enable.
- `ram_din`  out  8  RAM write data.
- `ram_dout`  in  8  RAM read data, synchronous (valid the cycle after `ram_a`).
- `uart_tx_data`  out  8  TX byte, the FIFO head.
- `uart_tx_valid`  out  1  TX FIFO non-empty.
- `uart_tx_ready`  in  1  UART accepts the head byte this cycle.
- `uart_rx_data`  in  8  received byte.
- `uart_rx_valid`  in  1  one-cycle strobe; push `uart_rx_data`.
- `program_done`  out  1  sticky; set by the stop write.
- `tx_overflow`  out  1  sticky; a TX push was dropped.

## Operation
- Decode on `cpu_a[17:16]`:
  - 00/01 → RAM.
  - 10 → hole: writes ignored, reads return 0x00.
  - 11 → I/O, using `cpu_a[2:0]`.
- RAM path is combinational:
  - `ram_a = cpu_a[16:0]`, `ram_din = cpu_dout`.
  - `ram_we = cpu_wr & RAM-decode & rst_in`.
- I/O writes:
  - 0x30000 with data ≠ 0 → push to TX FIFO. Data 0x00 is ignored.
  - 0x30004 → push 0x00 to TX FIFO and set `program_done`.
  - Any other I/O write is ignored.
  - Once `program_done` = 1, all I/O writes are ignored.
- I/O reads:
  - 0x30000 → pop the RX head and return it; returns 0x00 without popping if RX is empty.
  - 0x30004–0x30007 → counter byte `cpu_a[1:0]`, little-endian.
  - A read of 0x30004 returns the live `cycle_cnt[7:0]` and, in the same cycle, latches all 32 bits into `cnt_snap`.
  - Reads of 0x30005–0x30007 return bytes 1–3 of `cnt_snap`, so the four reads never tear.
  - Other I/O addresses read 0x00.
  - Every read cycle at 0x30000 with RX non-empty pops one byte. The CPU presents each I/O read address for exactly one cycle.
- Cycle counter: 32-bit `cycle_cnt`, 0 after reset, +1 every cycle, wraps 0xFFFFFFFF → 0.
- Read mux is registered:
  - `io_sel_q` and `io_data_q` capture the decode and I/O byte each cycle.
  - `cpu_din = io_sel_q ? io_data_q : ram_dout`.
  - The hole decode sets `io_sel_q = 1` with `io_data_q = 0`.
- TX FIFO:
  - Circular buffer with pointers of width `TX_DEPTH_LOG` + 1.
  - Pop when `uart_tx_valid & uart_tx_ready`.
  - A push is accepted if count < depth, or if a pop occurs in the same cycle. Otherwise the byte is dropped and `tx_overflow` is set.
  - `io_buffer_full = (count >= depth−1)`, leaving one slot of slack for a write already in flight.
- RX FIFO:
  - Same structure as TX.
  - A push when full is dropped silently.
  - Simultaneous push and pop leaves count unchanged.
- Pointer wrap: pointers wrap modulo 2·depth. Full = MSBs differ and low bits are equal.

## Timing
- Reset, `rst_in` = 0 sampled at an edge:
  - `cpu_din` = 0x00 (`io_sel_q` = 1, `io_data_q` = 0).
  - `io_buffer_full`, `uart_tx_valid`, `program_done`, `tx_overflow`, `ram_we` = 0.
  - Both FIFOs are emptied; `cycle_cnt` and `cnt_snap` = 0.
- Reset mid-operation discards FIFO contents and any in-flight read. `ram_we` is gated low combinationally while `rst_in` = 0.
- Read latency is exactly 1 cycle for both RAM and I/O.
- A TX push at edge t makes `uart_tx_valid` = 1 from t+1. A pop at edge t exposes the next head at t+1.
- `io_buffer_full` is registered-count based: it updates the cycle after the push or pop that changes the count.
- RX strobe at edge t makes the byte readable by a read issued at t+1 (data on `cpu_din` at t+2).
- `cnt_snap` is latched at the same edge where the 0x30004 read is sampled.

## Test plan
- **RAM**: write 0xA5 to 0x00123, then read 0x00123 → `ram_we` pulses 1 cycle; `cpu_din` = 0xA5 one cycle after the read address.
- **UART TX**: write 'H', 0x00, 'i' to 0x30000 with `uart_tx_ready` = 1 → TX emits 0x48 then 0x69 only; `tx_overflow` = 0.
- **TX backpressure**: hold `uart_tx_ready` = 0 and write 16 bytes → `io_buffer_full` rises after the 15th; the 16th is accepted; a 17th sets `tx_overflow`; release ready → 16 bytes drain in order.
- **Counter**: reset, then read 0x30004–0x30007 on consecutive cycles starting at cycle 0x1FF → assembled value = 0x1FF; no tearing across the 0x...FF→0x...00 carry.
- **RX**: strobe 0x31, 0x32, then read 0x30000 three times → 0x31, 0x32, 0x00.
- **Stop and reset**: write 0x30004 → `program_done` = 1 and 0x00 appears on TX; a later 0x30000 write is ignored; drop `rst_in` mid-drain → all outputs return to reset values next edge.
